// File: rtl/int_stim_pkg.sv
// Shared encodings for the interrupt stimulus controller: channel modes, channel
// FSM states and the default acknowledge address.
package int_stim_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ONESHOT = 2'd1,
    MODE_BUDGET  = 2'd2,
    MODE_FOREVER = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    CH_OFF   = 3'd0,
    CH_ARMED = 3'd1,
    CH_PEND  = 3'd2,
    CH_WAIT  = 3'd3,
    CH_DONE  = 3'd4
  } ch_state_e;

  localparam logic [31:0] DEFAULT_ACK_ADDR = 32'h0000_7f20;

endpackage

// File: rtl/int_stim_chan.sv
// One interrupt trigger channel: PC comparator, fire budget and the
// OFF/ARMED/PEND/WAIT/DONE sequencing.
module int_stim_chan
  import int_stim_pkg::*;
#(
  parameter int unsigned CntW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_we_i,
  input  logic [31:0]     cfg_pc_i,
  input  logic [1:0]      cfg_mode_i,
  input  logic [CntW-1:0] cfg_count_i,
  input  logic [31:0]     pc_i,
  input  logic            ack_i,
  output logic            pending_o,
  output logic            done_o
);

  ch_state_e       state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [31:2]     trig_q, trig_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            match;
  logic            exhausted;

  assign match     = (trig_q == pc_i[31:2]);
  assign exhausted = (mode_q == MODE_ONESHOT) || ((mode_q == MODE_BUDGET) && (cnt_q == '0));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    trig_d  = trig_q;
    cnt_d   = cnt_q;
    if (cfg_we_i) begin
      // Reconfiguration wins over any match or ack seen in the same cycle.
      trig_d  = cfg_pc_i[31:2];
      mode_d  = mode_e'(cfg_mode_i);
      cnt_d   = (cfg_count_i == '0) ? CntW'(1) : cfg_count_i;
      state_d = (cfg_mode_i == MODE_OFF) ? CH_OFF : CH_ARMED;
    end else begin
      unique case (state_q)
        CH_ARMED: begin
          if (match) begin
            state_d = CH_PEND;
            if ((mode_q == MODE_BUDGET) && (cnt_q != '0)) begin
              cnt_d = cnt_q - CntW'(1);
            end
          end
        end
        CH_PEND: begin
          if (ack_i) begin
            state_d = CH_WAIT;
          end
        end
        CH_WAIT: begin
          // Hold off until the PC leaves so a stalled CPU cannot re-fire.
          if (!match) begin
            state_d = exhausted ? CH_DONE : CH_ARMED;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CH_OFF;
      mode_q  <= MODE_OFF;
      trig_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      trig_q  <= trig_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pending_o = (state_q == CH_PEND);
  assign done_o    = (state_q == CH_DONE);

endmodule

// File: rtl/int_stim_ctrl.sv
// Multi-channel interrupt stimulus controller: per-channel triggers, a fixed
// priority arbiter, acknowledge decode and the registered CPU interrupt.
module int_stim_ctrl
  import int_stim_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter logic [31:0] ACK_ADDR = DEFAULT_ACK_ADDR,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned ID_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we_i,
  input  logic [ID_W-1:0]   cfg_ch_i,
  input  logic [31:0]       cfg_pc_i,
  input  logic [1:0]        cfg_mode_i,
  input  logic [CNT_W-1:0]  cfg_count_i,
  input  logic [31:0]       macroscopic_pc_i,
  input  logic [31:0]       m_int_addr_i,
  input  logic [3:0]        m_int_byteen_i,
  output logic              interrupt_o,
  output logic [ID_W-1:0]   int_id_o,
  output logic [NUM_CH-1:0] pending_o,
  output logic [NUM_CH-1:0] done_o
);

  logic              interrupt_q, interrupt_d;
  logic [ID_W-1:0]   int_id_q, int_id_d;
  logic [NUM_CH-1:0] pending, done;
  logic [NUM_CH-1:0] ack_vec, cfg_vec, surviving;
  logic [ID_W-1:0]   lowest;
  logic              ack;
  logic              hold;

  assign ack = interrupt_q && (|m_int_byteen_i) && (m_int_addr_i[31:2] == ACK_ADDR[31:2]);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    assign ack_vec[g] = ack && (int_id_q == ID_W'(g));
    assign cfg_vec[g] = cfg_we_i && (cfg_ch_i == ID_W'(g));

    int_stim_chan #(
      .CntW(CNT_W)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .cfg_we_i   (cfg_vec[g]),
      .cfg_pc_i   (cfg_pc_i),
      .cfg_mode_i (cfg_mode_i),
      .cfg_count_i(cfg_count_i),
      .pc_i       (macroscopic_pc_i),
      .ack_i      (ack_vec[g]),
      .pending_o  (pending[g]),
      .done_o     (done[g])
    );
  end

  // Channels still pending after this edge; new matches join one cycle later.
  assign surviving = pending & ~ack_vec & ~cfg_vec;

  always_comb begin
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (surviving[i]) begin
        lowest = ID_W'(i);
      end
    end
  end

  always_comb begin
    hold        = interrupt_q && surviving[int_id_q];
    interrupt_d = |surviving;
    int_id_d    = hold ? int_id_q : lowest;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      interrupt_q <= 1'b0;
      int_id_q    <= '0;
    end else begin
      interrupt_q <= interrupt_d;
      int_id_q    <= int_id_d;
    end
  end

  assign interrupt_o = interrupt_q;
  assign int_id_o    = int_id_q;
  assign pending_o   = pending;
  assign done_o      = done;

endmodule

// File: tb/tb_int_stim_ctrl.sv
// Directed bench for int_stim_ctrl: one-shot, budgeted repeat, PC stall,
// priority, ack filtering, reconfiguration and reset.
module tb_int_stim_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_pc;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_count;
  logic [31:0] pc;
  logic [31:0] st_addr;
  logic [3:0]  st_be;
  logic        interrupt;
  logic [1:0]  int_id;
  logic [3:0]  pending;
  logic [3:0]  done;

  int vecs = 0;
  int errs = 0;
  int fires;

  int_stim_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_we_i        (cfg_we),
    .cfg_ch_i        (cfg_ch),
    .cfg_pc_i        (cfg_pc),
    .cfg_mode_i      (cfg_mode),
    .cfg_count_i     (cfg_count),
    .macroscopic_pc_i(pc),
    .m_int_addr_i    (st_addr),
    .m_int_byteen_i  (st_be),
    .interrupt_o     (interrupt),
    .int_id_o        (int_id),
    .pending_o       (pending),
    .done_o          (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int ch, input logic [31:0] tpc, input int mode, input int cnt);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_pc    = tpc;
    cfg_mode  = 2'(mode);
    cfg_count = 8'(cnt);
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [3:0] be);
    st_addr = addr;
    st_be   = be;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_pc = '0; cfg_mode = '0; cfg_count = '0;
    pc = 32'h1000; st_addr = '0; st_be = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_irq", interrupt, 0);
    chk("rst_pend", pending, 0);
    chk("rst_done", done, 0);
    chk("rst_id", int_id, 0);

    // One-shot on ch0
    cfg(0, 32'h3010, 1, 0);
    pc = 32'h3010; tick();
    chk("os_pend", pending, 4'b0001);
    chk("os_irq_lat", interrupt, 0);
    pc = 32'h1000; tick();
    chk("os_irq", interrupt, 1);
    chk("os_id", int_id, 0);
    store(32'h7f20, 4'hf); tick();
    store(32'h0, 4'h0);
    chk("os_ack_irq", interrupt, 0);
    chk("os_ack_pend", pending, 0);
    tick();
    chk("os_done", done, 4'b0001);
    pc = 32'h3010; tick(); tick();
    chk("os_refire_pend", pending, 0);
    chk("os_refire_irq", interrupt, 0);
    pc = 32'h1000;

    // Budgeted repeat on ch1, count 3, five passes
    cfg(1, 32'h3008, 2, 3);
    fires = 0;
    for (int i = 0; i < 5; i++) begin
      pc = 32'h3008; tick();
      pc = 32'h1000; tick();
      chk("bud_irq", interrupt, (i < 3) ? 1 : 0);
      if (interrupt) fires++;
      store(32'h7f20, 4'hf); tick();
      store(32'h0, 4'h0); tick();
    end
    chk("bud_fires", fires, 3);
    chk("bud_done", done, 4'b0011);

    // PC stall on ch3 (unlimited)
    cfg(3, 32'h3008, 3, 0);
    pc = 32'h3008; tick(); tick();
    chk("stall_irq", interrupt, 1);
    chk("stall_id", int_id, 3);
    store(32'h7f20, 4'hf); tick();
    store(32'h0, 4'h0);
    tick(); tick(); tick();
    chk("stall_pend", pending, 0);
    chk("stall_irq_hold", interrupt, 0);
    pc = 32'h1000; tick();
    pc = 32'h3008; tick();
    chk("stall_refire", pending, 4'b1000);
    tick();
    chk("stall_refire_irq", interrupt, 1);
    store(32'h7f20, 4'hf); tick();
    store(32'h0, 4'h0);
    chk("stall_ack2", interrupt, 0);
    pc = 32'h1000;
    cfg(3, 32'h0, 0, 0);

    // Priority: ch0 and ch2 match together
    cfg(0, 32'h3020, 3, 0);
    cfg(2, 32'h3020, 1, 0);
    pc = 32'h3020; tick();
    chk("pri_pend", pending, 4'b0101);
    pc = 32'h1000; tick();
    chk("pri_irq", interrupt, 1);
    chk("pri_id0", int_id, 0);
    store(32'h7f20, 4'hf); tick();
    store(32'h0, 4'h0);
    chk("pri_irq_stay", interrupt, 1);
    chk("pri_id2", int_id, 2);
    chk("pri_pend2", pending, 4'b0100);
    store(32'h7f20, 4'hf); tick();
    store(32'h0, 4'h0);
    chk("pri_irq_drop", interrupt, 0);
    chk("pri_pend0", pending, 0);
    tick();
    chk("pri_done", done, 4'b0110);

    // Ack filtering (ch0 is armed again)
    pc = 32'h3020; store(32'h7f20, 4'hf); tick();
    pc = 32'h1000; tick();
    store(32'h0, 4'h0);
    chk("flt_noirq_ack", pending, 4'b0001);
    chk("flt_irq", interrupt, 1);
    store(32'h7f24, 4'hf); tick();
    chk("flt_addr", pending, 4'b0001);
    store(32'h7f20, 4'h0); tick();
    chk("flt_be0", pending, 4'b0001);
    chk("flt_be0_irq", interrupt, 1);
    store(32'h7f22, 4'h4); tick();
    store(32'h0, 4'h0);
    chk("flt_sub_ack_pend", pending, 0);
    chk("flt_sub_ack_irq", interrupt, 0);
    tick();

    // Reconfigure while pending and serviced
    pc = 32'h3020; tick();
    pc = 32'h1000; tick();
    chk("rcf_irq", interrupt, 1);
    cfg(0, 32'h3020, 3, 0);
    chk("rcf_pend", pending, 0);
    chk("rcf_irq_drop", interrupt, 0);

    // Reset mid-operation
    pc = 32'h3020; tick();
    pc = 32'h1000; tick();
    chk("mrst_pre_irq", interrupt, 1);
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("mrst_irq", interrupt, 0);
    chk("mrst_pend", pending, 0);
    chk("mrst_done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/int_stim_ctrl.md
Name: int_stim_ctrl

Overview:
- Synthesizable multi-channel interrupt stimulus controller for MIPS CPU bring-up and regression.
- Replaces the single hard-wired "fire once at one PC" injector with NUM_CH programmable channels.
- Each channel has a trigger PC, a mode and a fire budget.
- Drives the CPU `interrupt` input. Watches the CPU's interrupt-acknowledge store port (m_int_addr/m_int_byteen) to retire requests.

Parameters:
- NUM_CH, 4, number of independent trigger channels (1..16).
- ACK_ADDR, 32'h0000_7f20, word address whose store acknowledges the current interrupt.
- CNT_W, 8, width of per-channel fire budget.
- ID_W, $clog2(NUM_CH) (min 1), width of channel index.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cfg_we  in  1  write one channel's configuration this cycle.
- cfg_ch  in  ID_W  channel index for cfg_we.
- cfg_pc  in  32  trigger PC; bits [1:0] ignored.
- cfg_mode  in  2  0=off, 1=one-shot, 2=budgeted repeat, 3=unlimited repeat.
- cfg_count  in  CNT_W  fire budget for mode 2; 0 is treated as 1.
- macroscopic_pc  in  32  CPU macroscopic PC.
- m_int_addr  in  32  CPU store address (ack port).
- m_int_byteen  in  4  CPU store byte enables (ack port).
- interrupt  out  1  registered interrupt request to the CPU.
- int_id  out  ID_W  index of the channel currently being serviced.
- pending  out  NUM_CH  per-channel pending flags.
- done  out  NUM_CH  channel budget exhausted (modes 1/2).

Behaviour:
- Reset: all channels OFF, pending=0, done=0, interrupt=0, int_id=0, budgets=0.
- Per-channel FSM:
  - OFF: enters ARMED on cfg_we with mode≠0.
  - ARMED → PEND when (macroscopic_pc & ~3) == (trig_pc & ~3).
  - PEND → WAIT_LEAVE on ack of this channel.
  - WAIT_LEAVE → ARMED once the PC differs from trig_pc. Returns to DONE instead if the budget is exhausted; this holds for mode 1 always, and for mode 2 when the remaining count reaches 0.
  - DONE is sticky until reconfigured.
- Mode 3 never reaches DONE.
- Budget handling: mode 2 decrements the remaining count on each PEND entry. There is no wrap-around: a count of 0 in DONE is never decremented.
- Match timing:
  - A match sampled at posedge N sets pending at N.
  - `interrupt` = |pending, registered, so it is high after posedge N+1.
  - Latency from match to interrupt is one cycle.
- Arbitration: int_id is the lowest-index pending channel. It is registered together with `interrupt` and holds while interrupt=1 until an ack.
- Ack condition: interrupt=1, |m_int_byteen, and (m_int_addr & ~3) == ACK_ADDR.
  - The ack clears pending[int_id] only.
  - Stores to other addresses, and acks while interrupt=0, are ignored.
- After an ack:
  - interrupt drops the next cycle if no other channel is pending.
  - Otherwise interrupt stays high and int_id advances to the next lowest pending index.
- WAIT_LEAVE exists so a CPU stalled on the trigger PC cannot re-fire the same channel.
- Simultaneous events:
  - Ack and a new match on another channel: both take effect, and the new channel becomes pending.
  - Ack and a re-match on the same channel: ack wins, and the channel goes to WAIT_LEAVE.
  - cfg_we on a channel that is pending or being serviced: pending is cleared immediately and the channel reloads to ARMED (or OFF if mode 0). If it was int_id, arbitration re-evaluates next cycle.
  - cfg_we with a match in the same cycle: the new config applies, and the match is not registered until the next cycle.
- Reset mid-operation clears everything in the same edge; interrupt=0 after that edge.

Decomposition:
- Package int_stim_pkg holds:
  - mode encodings (MODE_OFF/ONESHOT/BUDGET/FOREVER);
  - channel state enum (CH_OFF, CH_ARMED, CH_PEND, CH_WAIT, CH_DONE);
  - default ACK_ADDR.
- Sub-module int_stim_chan: one channel FSM with budget counter and PC comparator. Instantiated NUM_CH times via generate.
- Top level holds the priority arbiter, ack decode and output registers.

Test Plan:
- One-shot: cfg ch0 pc=0x3010 mode1 → PC reaches 0x3010 → interrupt=1 one cycle later, int_id=0. Store byteen=4'hf to 0x7f20 → interrupt=0 next cycle, done[0]=1. PC revisiting 0x3010 → no fire.
- Budgeted repeat: ch1 pc=0x3008 mode2 count=3, loop through 0x3008 five times with ack each time → exactly 3 interrupts, then done[1]=1.
- PC stall: PC held at 0x3008 across ack → no re-fire until PC leaves and returns.
- Priority: ch2 and ch0 match in the same cycle → int_id=0 first. After ack, interrupt stays 1 with int_id=2. Second ack → interrupt=0.
- Ack filtering: store to 0x7f24, to 0x7f20 with byteen=0, and to 0x7f20 while interrupt=0 → pending unchanged. Store to 0x7f22 with byteen=4'h4 → accepted as ack.
- Reconfigure/reset: cfg_we on ch0 while it is pending → pending[0]=0 next cycle. Assert reset while interrupt=1 → interrupt, pending, done all 0 after the edge.
